crc8_frame_chk: RTL and testbench

Bit-serial CRC-8 frame checker that sits directly upstream of the CRC-valid register stage. It receives a framed serial bit stream, runs data and appended CRC bits through a CRC-8 LFSR, and at end of frame produces a one-cycle `frame_done` strobe plus a `crc_ok` qualifier. These two signals drive the downstream stage's two inputs, so that stage's output goes high only for a completed frame with a good CRC. It also keeps saturating frame and error counters for status readout.

---
 rtl/crc8_frame_chk.sv | 82 ++++++++
 tb/tb_crc8_frame_chk.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/crc8_frame_chk.sv
// Bit-serial CRC-8 frame checker: runs payload plus appended CRC through an MSB-first LFSR
// and flags each completed frame with a one-cycle strobe and a residue-zero qualifier.
module crc8_frame_chk #(
  parameter int         DATA_BITS = 32,
  parameter logic [7:0] POLY      = 8'h07,
  parameter logic [7:0] INIT      = 8'h00,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_vld,
  input  logic             sof,
  input  logic             din,
  output logic             busy,
  output logic             frame_done,
  output logic             crc_ok,
  output logic [CNT_W-1:0] frm_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // state | meaning
  // IDLE  | waiting for a sof bit; other bits are discarded
  // RUN   | accepting payload and CRC bits of the current frame
  typedef enum logic {IDLE, RUN} state_t;

  localparam int            BCNT_W = $clog2(DATA_BITS + 8) + 1;
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_BITS + 7);

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic d);
    logic fb;
    fb = c[7] ^ d;
    return {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  endfunction

  state_t            state;
  logic [7:0]        crc;
  logic [BCNT_W-1:0] bit_cnt;
  logic [7:0]        crc_run;
  logic [7:0]        crc_sof;

  assign crc_run = crc_upd(crc, din);
  assign crc_sof = crc_upd(INIT, din);
  assign busy    = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      crc        <= INIT;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      frm_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      if (din_vld) begin
        if (sof) begin
          // sof restarts the frame from either state; an interrupted frame is dropped silently
          state   <= RUN;
          crc     <= crc_sof;
          bit_cnt <= BCNT_W'(1);
        end else if (state == RUN) begin
          crc <= crc_run;
          if (bit_cnt == LAST_BIT) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            frame_done <= 1'b1;
            crc_ok     <= (crc_run == 8'h00);
            if (frm_cnt != '1)
              frm_cnt <= frm_cnt + 1'b1;
            if (crc_run != 8'h00 && err_cnt != '1)
              err_cnt <= err_cnt + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_crc8_frame_chk.sv
// Directed bench for crc8_frame_chk: an 8-bit-payload instance (2-bit counters) and a
// 72-bit-payload instance, checked with immediate assertions against hand-computed values.
module tb_crc8_frame_chk;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v8 = 1'b0, s8 = 1'b0, d8 = 1'b0;
  logic       v72 = 1'b0, s72 = 1'b0, d72 = 1'b0;
  logic       busy8, fd8, ok8;
  logic [1:0] frm8, err8;
  logic       busy72, fd72, ok72;
  logic [7:0] frm72, err72;

  int tests = 0;
  int failed = 0;
  int strobes8 = 0;

  always #5 clk = ~clk;

  crc8_frame_chk #(.DATA_BITS(8), .POLY(8'h07), .INIT(8'h00), .CNT_W(2)) u8 (
    .clk(clk), .rst(rst), .din_vld(v8), .sof(s8), .din(d8),
    .busy(busy8), .frame_done(fd8), .crc_ok(ok8), .frm_cnt(frm8), .err_cnt(err8));

  crc8_frame_chk #(.DATA_BITS(72), .POLY(8'h07), .INIT(8'h00), .CNT_W(8)) u72 (
    .clk(clk), .rst(rst), .din_vld(v72), .sof(s72), .din(d72),
    .busy(busy72), .frame_done(fd72), .crc_ok(ok72), .frm_cnt(frm72), .err_cnt(err72));

  always @(negedge clk) if (fd8) strobes8++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bit8(input logic s, input logic d);
    v8 = 1'b1; s8 = s; d8 = d;
    step();
    v8 = 1'b0; s8 = 1'b0;
  endtask

  task automatic frame8(input logic [15:0] f);
    for (int i = 15; i >= 0; i--) bit8(i == 15, f[i]);
  endtask

  task automatic frame72(input logic [79:0] f, input bit stall);
    for (int i = 79; i >= 0; i--) begin
      if (stall) begin
        for (int k = 0; k < 6 && $urandom_range(0, 1) == 1; k++) begin
          v72 = 1'b0; s72 = 1'b0;
          step();
        end
      end
      if (i == 0) check("fd72_before_last", {31'd0, fd72}, 32'd0);
      v72 = 1'b1; s72 = (i == 79); d72 = f[i];
      step();
      v72 = 1'b0; s72 = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [79:0] f72;
    int s0;
    f72 = {"123456789", 8'hF4};

    step();
    step();
    check("rst_busy",  {31'd0, busy8}, 32'd0);
    check("rst_fd",    {31'd0, fd8},   32'd0);
    check("rst_ok",    {31'd0, ok8},   32'd0);
    check("rst_frm",   {30'd0, frm8},  32'd0);
    check("rst_err",   {30'd0, err8},  32'd0);
    rst = 1'b0;
    step();

    // good frame 0x01 + CRC 0x07
    bit8(1'b1, 1'b0);
    check("t1_busy_rise", {31'd0, busy8}, 32'd1);
    for (int i = 14; i >= 1; i--) bit8(1'b0, i == 8 || i == 2 || i == 1 || i == 0);
    check("t1_fd_early", {31'd0, fd8}, 32'd0);
    bit8(1'b0, 1'b1);
    check("t1_fd",   {31'd0, fd8},   32'd1);
    check("t1_ok",   {31'd0, ok8},   32'd1);
    check("t1_frm",  {30'd0, frm8},  32'd1);
    check("t1_err",  {30'd0, err8},  32'd0);
    check("t1_busy_fall", {31'd0, busy8}, 32'd0);
    step();
    check("t1_fd_pulse", {31'd0, fd8}, 32'd0);
    check("t1_ok_low",   {31'd0, ok8}, 32'd0);

    // bad frame 0x01 + 0x06
    frame8(16'h0106);
    check("t2_fd",  {31'd0, fd8},  32'd1);
    check("t2_ok",  {31'd0, ok8},  32'd0);
    check("t2_err", {30'd0, err8}, 32'd1);
    check("t2_frm", {30'd0, frm8}, 32'd2);
    step();

    // reset during bit 10 of a frame
    for (int i = 15; i >= 6; i--) bit8(i == 15, 1'b1);
    check("t3_busy_pre", {31'd0, busy8}, 32'd1);
    v8 = 1'b1; d8 = 1'b1; rst = 1'b1;
    step();
    check("t3_busy_rst", {31'd0, busy8}, 32'd0);
    check("t3_frm_rst",  {30'd0, frm8},  32'd0);
    check("t3_err_rst",  {30'd0, err8},  32'd0);
    step();
    rst = 1'b0; v8 = 1'b0;
    step();
    check("t3_busy_post", {31'd0, busy8}, 32'd0);
    check("t3_fd_post",   {31'd0, fd8},   32'd0);
    check("t3_ok_post",   {31'd0, ok8},   32'd0);
    frame8(16'h0107);
    check("t3_fd",  {31'd0, fd8},  32'd1);
    check("t3_ok",  {31'd0, ok8},  32'd1);
    check("t3_frm", {30'd0, frm8}, 32'd1);
    step();

    // abort: sof again at payload bit 5
    do_reset();
    step();
    s0 = strobes8;
    for (int i = 0; i < 5; i++) bit8(i == 0, 1'b1);
    frame8(16'h0107);
    check("t4_ok",  {31'd0, ok8},  32'd1);
    check("t4_frm", {30'd0, frm8}, 32'd1);
    check("t4_err", {30'd0, err8}, 32'd0);
    step();
    check("t4_strobes", strobes8 - s0, 32'd1);

    // five back-to-back bad frames saturate the 2-bit counters
    do_reset();
    step();
    s0 = strobes8;
    for (int n = 0; n < 5; n++) frame8(16'h0106);
    check("t5_ok_last", {31'd0, ok8}, 32'd0);
    step();
    check("t5_strobes", strobes8 - s0, 32'd5);
    check("t5_frm", {30'd0, frm8}, 32'd3);
    check("t5_err", {30'd0, err8}, 32'd3);

    // 72-bit payload "123456789" + 0xF4, continuous then with random stalls
    frame72(f72, 1'b0);
    check("t6_fd",  {31'd0, fd72}, 32'd1);
    check("t6_ok",  {31'd0, ok72}, 32'd1);
    check("t6_frm", {24'd0, frm72}, 32'd1);
    step();
    frame72(f72, 1'b1);
    check("t7_fd",  {31'd0, fd72}, 32'd1);
    check("t7_ok",  {31'd0, ok72}, 32'd1);
    check("t7_frm", {24'd0, frm72}, 32'd2);
    check("t7_err", {24'd0, err72}, 32'd0);
    step();
    check("t7_busy", {31'd0, busy72}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
